// File: rtl/picovid_pkg.sv
// Shared types and constants for the picovid host-side receiver.
package picovid_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StGap
  } state_e;

  localparam int unsigned NUM_PULSES = 6;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 16;

  // Byte slot written by each strobe pulse, in pulse order.
  localparam logic [2:0] SLOT_A2    = 3'd0;
  localparam logic [2:0] SLOT_A1    = 3'd1;
  localparam logic [2:0] SLOT_A0    = 3'd2;
  localparam logic [2:0] SLOT_DH    = 3'd3;
  localparam logic [2:0] SLOT_DL    = 3'd4;
  localparam logic [2:0] SLOT_BLANK = 3'd5;

endpackage

// File: rtl/picovid_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module picovid_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/picovid_rx.sv
// Strobe master that reads one captured 68k write record per request from the capture CPLD.
// Optional RTS protocol checking is built when PICOVID_RX_RTSCHK_EN is defined.
module picovid_rx
  import picovid_pkg::*;
#(
  parameter int unsigned STB_LO = 4,
  parameter int unsigned STB_HI = 4,
  parameter int unsigned GAP    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RTS_N,
  input  logic [7:0]        D_IN,
  output logic              STB,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] OUT_ADDR,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              BUSY,
  output logic              ERR
);

  localparam int unsigned MaxCnt  = (STB_LO > STB_HI) ? ((STB_LO > GAP) ? STB_LO : GAP)
                                                      : ((STB_HI > GAP) ? STB_HI : GAP);
  localparam int unsigned CntW    = $clog2(MaxCnt);
  localparam logic [CntW-1:0] LoLast  = CntW'(STB_LO - 1);
  localparam logic [CntW-1:0] HiLast  = CntW'(STB_HI - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);
  localparam logic [2:0]      LastIdx = 3'(NUM_PULSES - 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          idx_q;
  logic [4:0][7:0]     d_q;
  logic                stb_q;
  logic                valid_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                rts_s;

  picovid_sync2 #(
    .ResetVal(1'b1)
  ) u_rts_sync (
    .clk_i(CLK),
    .rst_i(RESET),
    .d_i  (RTS_N),
    .q_o  (rts_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      d_q     <= '0;
      stb_q   <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (valid_q && OUT_READY) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        // A held record blocks new strobes; the CPLD keeps its record meanwhile.
        StIdle: begin
          if (!rts_s && !valid_q) begin
            state_q <= StLow;
            stb_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        StLow: begin
          if (cnt_q == LoLast) begin
            if (idx_q != SLOT_BLANK) begin
              d_q[idx_q] <= D_IN;
            end
            state_q <= StHigh;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHigh: begin
          if (cnt_q == HiLast) begin
            cnt_q <= '0;
            if (idx_q == LastIdx) begin
              state_q <= StGap;
              valid_q <= 1'b1;
              addr_q  <= {d_q[SLOT_A2], d_q[SLOT_A1], d_q[SLOT_A0]};
              data_q  <= {d_q[SLOT_DH], d_q[SLOT_DL]};
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StLow;
              stb_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // rts_s may still show the previous request here, so it is ignored.
        StGap: begin
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign STB       = stb_q;
  assign OUT_VALID = valid_q;
  assign OUT_ADDR  = addr_q;
  assign OUT_DATA  = data_q;
  assign BUSY      = busy_q;

`ifdef PICOVID_RX_RTSCHK_EN
  logic err_q;
  logic gap_entry;
  logic early_release;

  assign gap_entry     = (state_q == StHigh) && (cnt_q == HiLast) && (idx_q == LastIdx);
  assign early_release = ((state_q == StLow) || (state_q == StHigh)) && (idx_q < SLOT_DL) && rts_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if ((gap_entry && !rts_s) || early_release) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_picovid_rx.sv
// Randomized self-checking bench: two receivers (default and fast strobe timing) driven by a
// behavioural capture-CPLD model; expectations come from the requested records and timing rules.
module tb_picovid_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rts_n;
  logic [1:0]  ready;
  logic [7:0]  d_in0, d_in1;
  wire  [1:0]  stb, out_valid, busy, err;
  wire  [23:0] out_addr0, out_addr1;
  wire  [15:0] out_data0, out_data1;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  picovid_rx #(.STB_LO(4), .STB_HI(4), .GAP(4)) u_dut0 (
    .CLK(clk), .RESET(rst), .RTS_N(rts_n[0]), .D_IN(d_in0), .STB(stb[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(ready[0]), .OUT_ADDR(out_addr0),
    .OUT_DATA(out_data0), .BUSY(busy[0]), .ERR(err[0])
  );

  picovid_rx #(.STB_LO(2), .STB_HI(1), .GAP(3)) u_dut1 (
    .CLK(clk), .RESET(rst), .RTS_N(rts_n[1]), .D_IN(d_in1), .STB(stb[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(ready[1]), .OUT_ADDR(out_addr1),
    .OUT_DATA(out_data1), .BUSY(busy[1]), .ERR(err[1])
  );

  function automatic int lo_of(input int k);  return (k == 0) ? 4 : 2; endfunction
  function automatic int hi_of(input int k);  return (k == 0) ? 4 : 1; endfunction
  function automatic int gap_of(input int k); return (k == 0) ? 4 : 3; endfunction
  function automatic logic [23:0] addr_of(input int k); return (k == 0) ? out_addr0 : out_addr1; endfunction
  function automatic logic [15:0] data_of(input int k); return (k == 0) ? out_data0 : out_data1; endfunction

  // Requests from the test sequence to the CPLD model.
  int          kick_tog [2] = '{0, 0};
  logic [23:0] req_addr [2];
  logic [15:0] req_data [2];
  logic        req_hold [2];

  // CPLD model state and observations, owned by the model process.
  int          kick_seen [2];
  logic [23:0] m_addr [2];
  logic [15:0] m_data [2];
  logic        m_hold [2];
  logic [1:0]  prev_stb;
  int          m_pulse [2];
  int          fall_cnt [2];
  int          fall_cyc [2];
  int          rec_fall_cyc [2];
  int          rts_fall_cyc [2];
  int          width_bad [2];

  function automatic logic [7:0] cpld_byte(input logic [23:0] a, input logic [15:0] d, input int p);
    case (p)
      1: return a[23:16];
      2: return a[15:8];
      3: return a[7:0];
      4: return d[15:8];
      5: return d[7:0];
      default: return 8'($urandom);
    endcase
  endfunction

  always @(negedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rts_n[k]     = 1'b1;
        m_pulse[k]   = 0;
        kick_seen[k] = kick_tog[k];
        prev_stb[k]  = 1'b1;
        if (k == 0) d_in0 = 8'($urandom); else d_in1 = 8'($urandom);
      end else begin
        if (prev_stb[k] && !stb[k]) begin
          m_pulse[k] = m_pulse[k] + 1;
          if (m_pulse[k] > 1 && (cyc - fall_cyc[k] - lo_of(k)) != hi_of(k)) width_bad[k]++;
          if (m_pulse[k] == 1) rec_fall_cyc[k] = cyc;
          fall_cyc[k] = cyc;
          fall_cnt[k] = fall_cnt[k] + 1;
          if (k == 0) d_in0 = cpld_byte(m_addr[k], m_data[k], m_pulse[k]);
          else        d_in1 = cpld_byte(m_addr[k], m_data[k], m_pulse[k]);
          if (m_pulse[k] == 5 && !m_hold[k]) rts_n[k] = 1'b1;
          if (m_pulse[k] == 6) m_pulse[k] = 0;
        end else if (!prev_stb[k] && stb[k]) begin
          if ((cyc - fall_cyc[k]) != lo_of(k)) width_bad[k]++;
        end
        if (kick_tog[k] != kick_seen[k]) begin
          kick_seen[k]    = kick_tog[k];
          m_addr[k]       = req_addr[k];
          m_data[k]       = req_data[k];
          m_hold[k]       = req_hold[k];
          rts_n[k]        = 1'b0;
          rts_fall_cyc[k] = cyc;
        end
        prev_stb[k] = stb[k];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input int k, input logic [23:0] a, input logic [15:0] d, input logic hold);
    req_addr[k] = a;
    req_data[k] = d;
    req_hold[k] = hold;
    kick_tog[k] = kick_tog[k] + 1;
  endtask

  task automatic wait_valid(input int k, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = out_valid[k];
    end
  endtask

  task automatic wait_falls(input int k, input int target, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = (fall_cnt[k] >= target);
    end
  endtask

  task automatic pop(input int k);
    ready[k] = 1'b1;
    tick();
    ready[k] = 1'b0;
  endtask

  task automatic do_record(input int k, input logic [23:0] a, input logic [15:0] d,
                           input logic chk_lat);
    int   base, wb, v;
    logic seen;
    base = fall_cnt[k];
    wb   = width_bad[k];
    kick(k, a, d, 1'b0);
    wait_valid(k, 300, seen);
    v = cyc;
    check($sformatf("ch%0d valid_seen", k), seen, 1);
    if (chk_lat) check($sformatf("ch%0d latency", k), rec_fall_cyc[k] - rts_fall_cyc[k], 3);
    check($sformatf("ch%0d record_len", k), v - rec_fall_cyc[k], 6 * (lo_of(k) + hi_of(k)));
    check($sformatf("ch%0d addr", k), addr_of(k), a);
    check($sformatf("ch%0d data", k), data_of(k), d);
    check($sformatf("ch%0d busy_in_gap", k), busy[k], 1);
    repeat (gap_of(k) + 4) tick();
    check($sformatf("ch%0d pulses", k), fall_cnt[k] - base, 6);
    check($sformatf("ch%0d widths", k), width_bad[k] - wb, 0);
    check($sformatf("ch%0d idle_busy", k), busy[k], 0);
    check($sformatf("ch%0d held_addr", k), addr_of(k), a);
    pop(k);
    check($sformatf("ch%0d popped", k), out_valid[k], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic        seen;
    int          base, v, d;
    logic [23:0] ra;
    logic [15:0] rd;
    int          k;

    rst   = 1'b1;
    ready = 2'b00;
    repeat (3) tick();
    check("reset stb", stb, 2'b11);
    check("reset valid", out_valid, 2'b00);
    check("reset busy", busy, 2'b00);
    check("reset err", err, 2'b00);
    check("reset addr", out_addr0, 0);
    check("reset data", out_data1, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single record, and the fast-timing instance.
    do_record(0, 24'h078ABC, 16'h1234, 1'b1);
    do_record(1, 24'h078ABC, 16'h1234, 1'b1);

    // Backpressure: a second request must wait for the pop.
    kick(0, 24'h078000, 16'hAAAA, 1'b0);
    wait_valid(0, 300, seen);
    check("bp first_valid", seen, 1);
    check("bp first_addr", out_addr0, 24'h078000);
    check("bp first_data", out_data0, 16'hAAAA);
    base = fall_cnt[0];
    kick(0, 24'h078002, 16'h5555, 1'b0);
    repeat (60) tick();
    check("bp no_strobe", fall_cnt[0] - base, 0);
    check("bp still_valid", out_valid[0], 1);
    check("bp stable_addr", out_addr0, 24'h078000);
    pop(0);
    wait_valid(0, 300, seen);
    check("bp second_valid", seen, 1);
    check("bp second_addr", out_addr0, 24'h078002);
    check("bp second_data", out_data0, 16'h5555);
    repeat (8) tick();
    check("bp second_pulses", fall_cnt[0] - base, 6);
    pop(0);

    // Back-to-back: re-request right after the sixth falling edge.
    base = fall_cnt[0];
    kick(0, 24'h0A0010, 16'hC3C3, 1'b0);
    wait_falls(0, base + 6, 300, seen);
    check("b2b six_falls", seen, 1);
    kick(0, 24'h0A0012, 16'h3C3C, 1'b0);
    wait_valid(0, 300, seen);
    v = cyc;
    check("b2b first_valid", seen, 1);
    check("b2b first_addr", out_addr0, 24'h0A0010);
    check("b2b first_data", out_data0, 16'hC3C3);
    pop(0);
    wait_falls(0, base + 7, 100, seen);
    check("b2b restart", seen, 1);
    d = rec_fall_cyc[0] - (v + gap_of(0));
    check("b2b start_after_gap", (d >= 1 && d <= 3), 1);
    wait_valid(0, 300, seen);
    check("b2b second_valid", seen, 1);
    check("b2b second_addr", out_addr0, 24'h0A0012);
    check("b2b second_data", out_data0, 16'h3C3C);
    pop(0);
    repeat (8) tick();

    // Reset in the middle of pulse 3.
    base = fall_cnt[0];
    kick(0, 24'h012344, 16'h9999, 1'b0);
    wait_falls(0, base + 3, 300, seen);
    check("rst reached_pulse3", seen, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rst stb_high", stb[0], 1);
    check("rst busy", busy[0], 0);
    check("rst valid", out_valid[0], 0);
    check("rst addr_cleared", out_addr0, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    do_record(0, 24'h07FFFE, 16'hBEEF, 1'b1);

    // Random records on both instances.
    for (int i = 0; i < 8; i++) begin
      k  = int'($urandom_range(0, 1));
      ra = 24'($urandom) & 24'hFFFFFE;
      rd = 16'($urandom);
      do_record(k, ra, rd, 1'b1);
    end

`ifdef PICOVID_RX_RTSCHK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("rtschk clear", err[0], 0);
    base = fall_cnt[0];
    kick(0, 24'h055554, 16'h0F0F, 1'b1);
    wait_valid(0, 300, seen);
    check("rtschk valid", seen, 1);
    check("rtschk err_set", err[0], 1);
    check("rtschk addr", out_addr0, 24'h055554);
    check("rtschk data", out_data0, 16'h0F0F);
    repeat (20) tick();
    check("rtschk sticky", err[0], 1);
    check("rtschk no_restrobe", fall_cnt[0] - base, 6);
    rst = 1'b1;
    tick();
    check("rtschk reset_clears", err[0], 0);
    rst = 1'b0;
    tick();
`else
    check("err tied_low", err, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
